// File: rtl/mult_seq_if.sv
// Handshake/operand bundle for the sequential multiplier.
//   master: drives start, is_signed, multiplicand, multiplier; observes results
//   slave : the multiplier itself; drives busy, done, product, overflow
interface mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 overflow;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, product, overflow
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, product, overflow
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, WIDTH iterations per operation.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mult_seq_if slave -- start/is_signed/operands in,
//          busy/done/product/overflow out (all outputs registered)
// Signed operands are multiplied as magnitudes; the sign is reapplied in FIX.
// Latency from the accepting edge to done is WIDTH+1 edges; a new start is
// accepted in the done cycle, giving one result per WIDTH+2 cycles.
module mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    mult_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 signed_q, signed_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   res;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude (e.g. 0x80 -> 128).
    always_comb begin
        a_mag = (bus.is_signed && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
        b_mag = (bus.is_signed && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
        res   = neg_q ? -acc_q : acc_q;
    end

    // State register (and all other flops)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            signed_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            signed_q  <= signed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        signed_d  = signed_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
                    signed_d = bus.is_signed;
                    busy_d   = 1'b1;
                end
            end
            CALC: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
            FIX: begin
                product_d = res;
                // Signed fit: upper W+1 bits must be a pure sign extension.
                ovf_d     = signed_q ? !((&res[2*WIDTH-1:WIDTH-1]) || !(|res[2*WIDTH-1:WIDTH-1]))
                                     : (|res[2*WIDTH-1:WIDTH]);
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.product  = product_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_seq_if #(.WIDTH(W)) bus ();

    mult_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit              s;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [2*W-1:0]  p;
        bit              o;
        string           name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the interpreted operand values.
    function automatic void model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] p, output bit o);
        longint x, y, r;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        r = x * y;
        p = r[2*W-1:0];
        if (s) o = (r < -(longint'(1) << (W-1))) || (r > (longint'(1) << (W-1)) - 1);
        else   o = (r > (longint'(1) << W) - 1);
    endfunction

    // Enter at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit timing, output logic [2*W-1:0] p, output logic o);
        bus.start = 1'b1; bus.is_signed = s; bus.multiplicand = a; bus.multiplier = b;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        bus.is_signed = 1'($urandom); bus.multiplicand = W'($urandom); bus.multiplier = W'($urandom);
        if (timing) begin
            check("busy_e0", bus.busy, 1);
            check("done_e0", bus.done, 0);
        end
        for (int k = 1; k <= W + 1; k++) begin
            bus.start = 1'($urandom);
            bus.multiplicand = W'($urandom);
            @(posedge clk); @(negedge clk);
            if (timing && k <= W) begin
                check("busy_calc", bus.busy, 1);
                check("done_early", bus.done, 0);
            end
        end
        bus.start = 1'b0;
        check("done_pulse", bus.done, 1);
        check("busy_end", bus.busy, 0);
        p = bus.product;
        o = bus.overflow;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] ext [4];
        ext[0] = 8'h00; ext[1] = 8'h7F; ext[2] = 8'h80; ext[3] = 8'hFF;
        if ($urandom_range(0, 3) == 0) return ext[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        logic [2*W-1:0] p, mp;
        logic o;
        bit mo, s;
        logic [W-1:0] a, b;
        int dones;

        vecs.push_back('{0, 8'd5,   8'd7,   16'h0023, 0, "u5x7"});
        vecs.push_back('{0, 8'hFF,  8'hFF,  16'hFE01, 1, "u255x255"});
        vecs.push_back('{0, 8'd15,  8'd17,  16'h00FF, 0, "u15x17"});
        vecs.push_back('{1, 8'hFD,  8'h07,  16'hFFEB, 0, "s-3x7"});
        vecs.push_back('{1, 8'h80,  8'h80,  16'h4000, 1, "s-128x-128"});
        vecs.push_back('{1, 8'h80,  8'h01,  16'hFF80, 0, "s-128x1"});
        vecs.push_back('{0, 8'hFF,  8'h00,  16'h0000, 0, "u255x0"});
        vecs.push_back('{1, 8'h80,  8'h00,  16'h0000, 0, "s-128x0"});
        vecs.push_back('{1, 8'h00,  8'hFF,  16'h0000, 0, "s0x-1"});
        vecs.push_back('{0, 8'h80,  8'h80,  16'h4000, 1, "u128x128"});
        vecs.push_back('{1, 8'h7F,  8'h7F,  16'h3F01, 1, "s127x127"});
        vecs.push_back('{1, 8'hFF,  8'hFF,  16'h0001, 0, "s-1x-1"});
        vecs.push_back('{1, 8'h80,  8'hFF,  16'h0080, 1, "s-128x-1"});

        rst = 1'b1; bus.start = 1'b0; bus.is_signed = 1'b0;
        bus.multiplicand = '0; bus.multiplier = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_product", bus.product, 0);
        check("rst_ovf", bus.overflow, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, 1'b1, p, o);
            check({vecs[i].name, "_p"}, p, vecs[i].p);
            check({vecs[i].name, "_o"}, o, vecs[i].o);
        end
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("product_hold", bus.product, 16'h0080);

        // Start pulse during CALC must be ignored, then restart in the done cycle.
        for (int e = 0; e <= 9; e++) begin
            bus.start = (e == 0 || e == 3);
            if (e == 0) begin bus.is_signed = 0; bus.multiplicand = 8'd5; bus.multiplier = 8'd7; end
            if (e == 3) begin bus.multiplicand = 8'd9; bus.multiplier = 8'd9; end
            @(posedge clk); @(negedge clk);
            bus.start = 1'b0;
            if (e < 9) begin
                check("b2b_busy", bus.busy, 1);
                check("b2b_nodone", bus.done, 0);
            end
        end
        check("b2b_done9", bus.done, 1);
        check("b2b_p1", bus.product, 16'h0023);
        run_op(1'b0, 8'd9, 8'd9, 1'b1, p, o);
        check("b2b_p2", p, 16'h0051);
        @(negedge clk);

        // Reset mid-operation aborts with no done.
        for (int e = 0; e <= 4; e++) begin
            bus.start = (e == 0);
            if (e == 0) begin bus.is_signed = 0; bus.multiplicand = 8'd100; bus.multiplier = 8'd100; end
            rst = (e == 4);
            @(posedge clk); @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_product", bus.product, 0);
        check("abort_ovf", bus.overflow, 0);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(1'b0, 8'd2, 8'd3, 1'b1, p, o);
        check("after_rst_p", p, 16'h0006);
        check("after_rst_o", o, 0);

        // Random regression, back-to-back.
        for (int i = 0; i < 4000; i++) begin
            s = 1'($urandom);
            a = pick();
            b = pick();
            run_op(s, a, b, 1'b0, p, o);
            model(s, a, b, mp, mo);
            check("rand_p", p, mp);
            check("rand_o", o, mo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
